register_file_mp: RTL and testbench

Parametrised multi-port register file with a write-through bypass, an optional hardwired-zero register, a per-register pending scoreboard, and a sequential hardware clear after reset. It sits in the CPU decode stage as the architectural register store. The scoreboard lets the hazard unit stall on registers whose producer has not yet written back.

---
 rtl/register_file_pkg.sv | 19 +
 rtl/register_scoreboard.sv | 42 ++++
 rtl/register_file_mp.sv | 114 +++++++++++
 tb/tb_register_file_mp.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | register_file_pkg : shared widths and clear-FSM state encodings       |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package register_file_pkg;

  // Defaults shared with decode and the hazard unit.
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_NUM_READ   = 2;
  localparam int RF_DEPTH      = 2 ** RF_ADDR_WIDTH;

  localparam int       STATE_W  = 1;
  localparam logic [STATE_W-1:0] ST_CLEAR = 1'b0;
  localparam logic [STATE_W-1:0] ST_READY = 1'b1;

endpackage
`default_nettype wire

// File: rtl/register_scoreboard.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | register_scoreboard : per-register pending bits, set wins over clear  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module register_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rst_i,
  input  logic                           set_en_i,
  input  logic [ADDR_WIDTH-1:0]          set_addr_i,
  input  logic                           clr_en_i,
  input  logic [ADDR_WIDTH-1:0]          clr_addr_i,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] lookup_addr_i,
  output logic [NUM_READ-1:0]            pending_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // Clear applied first so a same-cycle set (new producer) survives.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) pending_d[clr_addr_i] = 1'b0;
    if (set_en_i) pending_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_i) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_lookup
    assign pending_o[i] = pending_q[lookup_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]];
  end

endmodule
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | register_file_mp : multi-port register file, bypass, hardware clear   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_READ   = RF_NUM_READ,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           write_enable,
  input  logic [ADDR_WIDTH-1:0]          write_address,
  input  logic [DATA_WIDTH-1:0]          write_value,
  input  logic                           mark_enable,
  input  logic [ADDR_WIDTH-1:0]          mark_address,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_address,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_value,
  output logic [NUM_READ-1:0]            read_pending,
  output logic                           busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [STATE_W-1:0]    state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_cnt_q, clear_cnt_d;

  logic                  w_ready;
  logic                  w_clear_wr;
  logic                  w_wr_en;
  logic                  w_mark_en;
  logic [NUM_READ-1:0]   w_sb_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clear_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clear_cnt_d = clear_cnt_q + 1'b1;
        if (clear_cnt_q == '1) state_d = ST_READY;
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    busy       = (state_q == ST_CLEAR);
    w_ready    = (state_q == ST_READY);
    w_clear_wr = (state_q == ST_CLEAR);
    w_wr_en    = w_ready && write_enable &&
                 !((ZERO_REG != 0) && (write_address == '0));
    w_mark_en  = w_ready && mark_enable &&
                 !((ZERO_REG != 0) && (mark_address == '0));
  end

  // The array has no reset; the clear sequence initialises it instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_clear_wr)   mem_q[clear_cnt_q]   <= '0;
      else if (w_wr_en) mem_q[write_address] <= write_value;
    end
  end

  register_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ)
  ) u_scoreboard (
    .clk           (clk),
    .rst_i         (reset),
    .set_en_i      (w_mark_en),
    .set_addr_i    (mark_address),
    .clr_en_i      (w_wr_en),
    .clr_addr_i    (write_address),
    .lookup_addr_i (read_address),
    .pending_o     (w_sb_pending)
  );

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic                  w_zero;
    logic                  w_fwd;

    assign w_raddr = read_address[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_zero  = (ZERO_REG != 0) && (w_raddr == '0);
    assign w_fwd   = (BYPASS != 0) && w_ready && write_enable &&
                     (w_raddr == write_address);

    assign read_value[i*DATA_WIDTH +: DATA_WIDTH] =
        (!w_ready || w_zero) ? '0 :
        w_fwd                ? write_value :
                               mem_q[w_raddr];

    assign read_pending[i] = w_ready && !w_zero && !w_fwd && w_sb_pending[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_register_file_mp : queue-scoreboard bench, BYPASS=1 and BYPASS=0   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              write_enable;
  logic [AW-1:0]     write_address;
  logic [DW-1:0]     write_value;
  logic              mark_enable;
  logic [AW-1:0]     mark_address;
  logic [NR*AW-1:0]  read_address;
  logic [NR*DW-1:0]  rv_b, rv_nb;
  logic [NR-1:0]     rp_b, rp_nb;
  logic              busy_b, busy_nb;

  always #5 clk = ~clk;

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
                     .ZERO_REG(1), .BYPASS(1)) u_dut_b (
    .clk(clk), .reset(reset), .write_enable(write_enable),
    .write_address(write_address), .write_value(write_value),
    .mark_enable(mark_enable), .mark_address(mark_address),
    .read_address(read_address), .read_value(rv_b),
    .read_pending(rp_b), .busy(busy_b)
  );

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
                     .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .clk(clk), .reset(reset), .write_enable(write_enable),
    .write_address(write_address), .write_value(write_value),
    .mark_enable(mark_enable), .mark_address(mark_address),
    .read_address(read_address), .read_value(rv_nb),
    .read_pending(rp_nb), .busy(busy_nb)
  );

  // Reference model of the architectural state
  logic [DW-1:0] m_mem [32];
  logic [31:0]   m_pend;
  logic          m_busy;
  int            m_cnt;

  string         q_tag[$];
  logic [31:0]   q_val[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    q_tag.push_back(tag);
    q_val.push_back(v);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       t;
    logic [31:0] v;
    t = q_tag.pop_front();
    v = q_val.pop_front();
    check(t, obs, v);
  endtask

  task automatic expect_port(input int d, input int p, input logic [AW-1:0] a);
    logic [31:0] v;
    logic        pd;
    if (m_busy || a == 0) begin
      v = '0; pd = 1'b0;
    end else if (d == 0 && write_enable && a == write_address) begin
      v = write_value; pd = 1'b0;
    end else begin
      v = m_mem[a]; pd = m_pend[a];
    end
    push_exp($sformatf("d%0d.rv%0d[r%0d]", d, p, a), v);
    push_exp($sformatf("d%0d.rp%0d[r%0d]", d, p, a), {31'b0, pd});
  endtask

  task automatic model_update(input logic rst, input logic we, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wv, input logic me, input logic [AW-1:0] ma);
    if (rst) begin
      m_busy = 1'b1; m_cnt = 0; m_pend = '0;
    end else if (m_busy) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == 31) m_busy = 1'b0;
      m_cnt++;
    end else begin
      if (we && wa != 0) begin m_mem[wa] = wv; m_pend[wa] = 1'b0; end
      if (me && ma != 0) m_pend[ma] = 1'b1;
    end
  endtask

  // One clock: drive after the edge, sample at the falling edge, update model at the next edge.
  task automatic step(input logic rst, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wv, input logic me, input logic [AW-1:0] ma,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1, input bit chk);
    reset = rst; write_enable = we; write_address = wa; write_value = wv;
    mark_enable = me; mark_address = ma; read_address = {a1, a0};
    if (chk) begin
      for (int d = 0; d < 2; d++) begin
        push_exp($sformatf("d%0d.busy", d), {31'b0, m_busy});
        expect_port(d, 0, a0);
        expect_port(d, 1, a1);
      end
    end
    @(negedge clk);
    if (chk) begin
      for (int d = 0; d < 2; d++) begin
        pop_check({31'b0, (d == 0) ? busy_b : busy_nb});
        for (int p = 0; p < 2; p++) begin
          pop_check((d == 0) ? rv_b[p*DW +: DW] : rv_nb[p*DW +: DW]);
          pop_check({31'b0, (d == 0) ? rp_b[p] : rp_nb[p]});
        end
      end
    end
    @(posedge clk);
    model_update(rst, we, wa, wv, me, ma);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, a0, a1, 1'b1);
  endtask

  task automatic clear_phase();
    for (int k = 0; k < 32; k++)
      step(1'b0, (k == 20), 5'd5, 32'hDEADBEEF, (k == 21), 5'd5,
           5'(k), 5'(31 - k), 1'b1);
  endtask

  task automatic read_all();
    for (int k = 0; k < 16; k++) rd(5'(2 * k), 5'(2 * k + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time bound");
    $fatal(1);
  end

  initial begin
    m_busy = 1'b1; m_cnt = 0; m_pend = '0;
    reset = 1'b1; write_enable = 1'b0; write_address = '0; write_value = '0;
    mark_enable = 1'b0; mark_address = '0; read_address = '0;
    @(posedge clk); #1;

    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd1, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd7, 1'b1);
    step(1'b1, 1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 5'd9, 5'd31, 1'b1);

    clear_phase();
    read_all();

    // Bypass vs. array latency
    step(1'b0, 1'b1, 5'd7, 32'h12345678, 1'b0, '0, 5'd7, 5'd6, 1'b1);
    rd(5'd7, 5'd7);

    // Hardwired zero
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, 5'd0, 5'd0, 1'b1);
    rd(5'd0, 5'd0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    rd(5'd0, 5'd0);

    // Pending set, then cleared by writeback
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1);
    rd(5'd3, 5'd2);
    rd(5'd3, 5'd3);
    step(1'b0, 1'b1, 5'd3, 32'hA5, 1'b0, '0, 5'd3, 5'd3, 1'b1);
    rd(5'd3, 5'd3);

    // Same-cycle write and mark: mark wins
    step(1'b0, 1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 5'd4, 5'd1, 1'b1);
    rd(5'd4, 5'd4);

    for (int k = 0; k < 60; k++)
      step(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'b1);

    // Reset mid-clear at clear_count = 10
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd4, 1'b1);
    for (int k = 0; k < 10; k++) rd(5'(k), 5'd7);
    step(1'b1, 1'b1, 5'd12, 32'hCAFE, 1'b0, '0, 5'd12, 5'd4, 1'b1);
    clear_phase();
    read_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
